// File: rtl/tlu_issue_queue_if.sv
// Request, TLU-issue and response signal bundle for tlu_issue_queue.
// The slave modport is the queue itself; master is the surrounding logic.
interface tlu_issue_queue_if #(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [35:0]      req_a;
   logic [35:0]      req_b;
   logic [35:0]      req_c;
   logic [TAG_W-1:0] req_tag;

   logic             tlu_enable;
   logic [3:0]       tlu_operation;
   logic [35:0]      tlu_operand_a;
   logic [35:0]      tlu_operand_b;
   logic [35:0]      tlu_operand_c;
   logic [35:0]      tlu_result;
   logic             tlu_valid;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [35:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_bad_trit;
   logic             rsp_timeout;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_c, req_tag,
      input  tlu_result, tlu_valid, rsp_ready,
      output req_ready,
      output tlu_enable, tlu_operation, tlu_operand_a, tlu_operand_b, tlu_operand_c,
      output rsp_valid, rsp_result, rsp_tag, rsp_bad_trit, rsp_timeout
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_c, req_tag,
      output tlu_result, tlu_valid, rsp_ready,
      input  req_ready,
      input  tlu_enable, tlu_operation, tlu_operand_a, tlu_operand_b, tlu_operand_c,
      input  rsp_valid, rsp_result, rsp_tag, rsp_bad_trit, rsp_timeout
   );
endinterface

// File: rtl/tlu_issue_queue.sv
// Request FIFO and one-at-a-time sequencer in front of the ternary logic unit.
// state | meaning: IDLE fifo empty | ISSUE enable pulse, pop head | WAIT await tlu_valid | RESP hold response
module tlu_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   tlu_issue_queue_if.slave         bus,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;

   logic [3:0]       r_op  [DEPTH];
   logic [35:0]      r_a   [DEPTH];
   logic [35:0]      r_b   [DEPTH];
   logic [35:0]      r_c   [DEPTH];
   logic [TAG_W-1:0] r_tag [DEPTH];

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [7:0]       r_wd;

   logic [35:0]      r_rsp_result;
   logic [TAG_W-1:0] r_rsp_tag;
   logic             r_rsp_bad;
   logic             r_rsp_timeout;

   logic             w_push;
   logic             w_pop;
   logic             w_head_bad;
   logic             w_wd_expired;
   logic             w_issue;

   function automatic logic has_bad_trit(input logic [35:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (v[2*i +: 2] == 2'b11) bad = 1'b1;
      end
      return bad;
   endfunction

   assign bus.req_ready = (r_count < CW'(DEPTH));
   assign w_push        = bus.req_valid && bus.req_ready;
   assign w_pop         = (r_state == S_ISSUE);
   assign w_issue       = (r_state == S_ISSUE);
   assign w_head_bad    = has_bad_trit(r_a[r_rd_ptr]) | has_bad_trit(r_b[r_rd_ptr])
                        | has_bad_trit(r_c[r_rd_ptr]);
   assign w_wd_expired  = (r_wd == 8'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_op[r_wr_ptr]  <= bus.req_op;
         r_a[r_wr_ptr]   <= bus.req_a;
         r_b[r_wr_ptr]   <= bus.req_b;
         r_c[r_wr_ptr]   <= bus.req_c;
         r_tag[r_wr_ptr] <= bus.req_tag;
      end
   end

   // Pointers are AW bits wide so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (bus.tlu_valid || w_wd_expired) w_next = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_next = (r_count != '0) ? S_ISSUE : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // A real result wins over an expiring watchdog in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd          <= '0;
         r_rsp_result  <= '0;
         r_rsp_tag     <= '0;
         r_rsp_bad     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_ISSUE: begin
               r_rsp_tag <= r_tag[r_rd_ptr];
               r_rsp_bad <= w_head_bad;
               r_wd      <= '0;
            end
            S_WAIT: begin
               if (bus.tlu_valid) begin
                  r_rsp_result  <= bus.tlu_result;
                  r_rsp_timeout <= 1'b0;
               end else if (w_wd_expired) begin
                  r_rsp_result  <= '0;
                  r_rsp_timeout <= 1'b1;
               end else begin
                  r_wd <= r_wd + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tlu_enable    = w_issue;
   assign bus.tlu_operation = w_issue ? r_op[r_rd_ptr] : 4'd0;
   assign bus.tlu_operand_a = w_issue ? r_a[r_rd_ptr]  : 36'd0;
   assign bus.tlu_operand_b = w_issue ? r_b[r_rd_ptr]  : 36'd0;
   assign bus.tlu_operand_c = w_issue ? r_c[r_rd_ptr]  : 36'd0;

   assign bus.rsp_valid     = (r_state == S_RESP);
   assign bus.rsp_result    = r_rsp_result;
   assign bus.rsp_tag       = r_rsp_tag;
   assign bus.rsp_bad_trit  = r_rsp_bad;
   assign bus.rsp_timeout   = r_rsp_timeout;

   assign count = r_count;
endmodule

// File: tb/tb_tlu_issue_queue.sv
// Randomized scoreboard bench for tlu_issue_queue with a behavioural TLU and queue model.
module tb_tlu_issue_queue;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] count;

   tlu_issue_queue_if #(.TAG_W(TAG_W)) bus();

   tlu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       op;
      logic [35:0]      a, b, c;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef struct {
      logic [35:0]      result;
      logic [TAG_W-1:0] tag;
      logic             bt;
      logic             tmo;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   mcount = 0;
   bit   busy = 0;
   int   exp_en = -1;
   int   exp_rsp = 0;
   bit   mute = 0;
   bit   hold = 0;
   rsp_t held;

   bit   was_busy, push, acc, en_exp;
   req_t mr;
   rsp_t me;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int trit_val(input logic [1:0] t);
      if (t == 2'b01) return -1;
      if (t == 2'b10) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] trit_code(input int v);
      if (v < 0) return 2'b01;
      if (v > 0) return 2'b10;
      return 2'b00;
   endfunction

   // Behavioural TLU: op 0 is trit-wise minimum (ternary AND), others a simple mix.
   function automatic logic [35:0] tlu_fn(input logic [3:0] op, input logic [35:0] a,
                                          input logic [35:0] b, input logic [35:0] c);
      logic [35:0] v;
      int x, y;
      if (op != 4'd0) return a ^ b ^ c ^ {9{op}};
      v = '0;
      for (int i = 0; i < 18; i++) begin
         x = trit_val(a[2*i +: 2]);
         y = trit_val(b[2*i +: 2]);
         v[2*i +: 2] = trit_code((x < y) ? x : y);
      end
      return v;
   endfunction

   function automatic bit any_bad(input logic [35:0] a, input logic [35:0] b, input logic [35:0] c);
      logic [107:0] all;
      all = {a, b, c};
      for (int i = 0; i < 54; i++) if (all[2*i +: 2] == 2'b11) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [35:0] rand_trits(input int bad_one_in);
      logic [35:0] v;
      int r, k;
      for (int i = 0; i < 18; i++) begin
         r = int'($urandom_range(0, 2));
         v[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
      end
      if (bad_one_in > 0 && $urandom_range(0, bad_one_in - 1) == 0) begin
         k = int'($urandom_range(0, 17));
         v[2*k +: 2] = 2'b11;
      end
      return v;
   endfunction

   // TLU stand-in: registers a result one cycle after it sees enable.
   initial begin
      bit          en_s, ms;
      logic [35:0] r;
      bus.tlu_valid  = 1'b0;
      bus.tlu_result = '0;
      forever begin
         @(negedge clk);
         en_s = bus.tlu_enable;
         ms   = mute;
         r    = tlu_fn(bus.tlu_operation, bus.tlu_operand_a, bus.tlu_operand_b, bus.tlu_operand_c);
         @(posedge clk);
         #1;
         bus.tlu_valid  = en_s && !ms;
         bus.tlu_result = (en_s && !ms) ? r : 36'({$urandom(), $urandom()});
      end
   end

   // Monitor / scoreboard: model of occupancy, issue timing and response timing.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            req_q.delete();
            rsp_q.delete();
            mcount = 0;
            busy   = 0;
            exp_en = -1;
            hold   = 0;
         end else begin
            was_busy = busy;
            push     = bus.req_valid && (mcount < DEPTH);
            acc      = 0;
            en_exp   = (cyc == exp_en);
            chk("count", 128'(count), 128'(mcount));
            chk("req_ready", 128'(bus.req_ready), 128'(mcount < DEPTH));
            chk("tlu_enable", 128'(bus.tlu_enable), 128'(en_exp));
            chk("rsp_valid", 128'(bus.rsp_valid), 128'(busy && cyc >= exp_rsp));
            if (!bus.tlu_enable)
               chk("tlu_bus_idle", 128'({bus.tlu_operation, bus.tlu_operand_a,
                                         bus.tlu_operand_b, bus.tlu_operand_c}), 128'(0));
            if (en_exp) begin
               if (req_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL issue_empty: got issue expected none at cycle %0d", cyc);
               end else begin
                  mr = req_q.pop_front();
                  if (bus.tlu_enable)
                     chk("issue_data", 128'({bus.tlu_operation, bus.tlu_operand_a,
                                            bus.tlu_operand_b, bus.tlu_operand_c}),
                         128'({mr.op, mr.a, mr.b, mr.c}));
                  me.result = mute ? 36'd0 : tlu_fn(mr.op, mr.a, mr.b, mr.c);
                  me.tag    = mr.tag;
                  me.bt     = any_bad(mr.a, mr.b, mr.c);
                  me.tmo    = mute;
                  rsp_q.push_back(me);
                  busy    = 1;
                  exp_rsp = cyc + (mute ? TIMEOUT + 2 : 2);
               end
            end
            if (bus.rsp_valid) begin
               if (hold)
                  chk("rsp_stable", 128'({bus.rsp_result, bus.rsp_tag, bus.rsp_bad_trit, bus.rsp_timeout}),
                      128'({held.result, held.tag, held.bt, held.tmo}));
               if (bus.rsp_ready) begin
                  acc  = 1;
                  hold = 0;
                  if (rsp_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL rsp_unexpected: got tag %0h expected none at cycle %0d", bus.rsp_tag, cyc);
                  end else begin
                     me = rsp_q.pop_front();
                     chk("rsp_result", 128'(bus.rsp_result), 128'(me.result));
                     chk("rsp_tag", 128'(bus.rsp_tag), 128'(me.tag));
                     chk("rsp_bad_trit", 128'(bus.rsp_bad_trit), 128'(me.bt));
                     chk("rsp_timeout", 128'(bus.rsp_timeout), 128'(me.tmo));
                  end
                  busy = 0;
                  if (mcount > 0) exp_en = cyc + 1;
               end else begin
                  hold        = 1;
                  held.result = bus.rsp_result;
                  held.tag    = bus.rsp_tag;
                  held.bt     = bus.rsp_bad_trit;
                  held.tmo    = bus.rsp_timeout;
               end
            end else begin
               hold = 0;
            end
            if (push) begin
               mr.op = bus.req_op; mr.a = bus.req_a; mr.b = bus.req_b; mr.c = bus.req_c;
               mr.tag = bus.req_tag;
               req_q.push_back(mr);
               if (mcount == 0 && (!was_busy || acc)) exp_en = cyc + 2;
            end
            mcount = mcount + (push ? 1 : 0) - (en_exp ? 1 : 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [35:0] a, input logic [35:0] b,
                       input logic [35:0] c, input logic [TAG_W-1:0] tag);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_tag = tag;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 200) begin
            total++; bad++;
            $display("FAIL send_timeout: got no req_ready expected acceptance for tag %0h", tag);
            break;
         end
      end
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!busy && mcount == 0 && req_q.size() == 0 && rsp_q.size() == 0) break;
         n++;
         if (n > 400) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", rsp_q.size() + mcount);
            break;
         end
      end
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
      bus.req_tag = '0; bus.rsp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", 128'({bus.rsp_valid, bus.tlu_enable, bus.rsp_result, bus.rsp_tag,
                                 bus.rsp_bad_trit, bus.rsp_timeout, count}), 128'(0));
      chk("reset_req_ready", 128'(bus.req_ready), 128'(1));
      tick();

      send(4'd0, 36'h2AAAAAAAA, 36'h0, 36'h0, 4'd5);
      wait_drain();

      bus.rsp_ready = 1'b0;
      fork
         begin
            for (int t = 0; t < 6; t++)
               send(4'($urandom_range(0, 15)), rand_trits(0), rand_trits(0), rand_trits(0), 4'(t));
         end
         begin
            repeat (20) tick();
            bus.rsp_ready = 1'b1;
         end
      join
      wait_drain();

      send(4'd1, 36'h3, rand_trits(0), rand_trits(0), 4'd2);
      wait_drain();

      mute = 1'b1;
      send(4'd2, rand_trits(0), rand_trits(0), rand_trits(0), 4'd7);
      wait_drain();
      mute = 1'b0;
      send(4'd0, rand_trits(0), rand_trits(0), rand_trits(0), 4'd8);
      wait_drain();

      repeat (400) begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_op    = 4'($urandom_range(0, 15));
         bus.req_a     = rand_trits(12);
         bus.req_b     = rand_trits(12);
         bus.req_c     = rand_trits(12);
         bus.req_tag   = 4'($urandom_range(0, 15));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) mute = ~mute;
         tick();
      end
      bus.req_valid = 1'b0;
      mute = 1'b0;
      wait_drain();

      mute = 1'b1;
      bus.rsp_ready = 1'b0;
      for (int t = 0; t < 4; t++)
         send(4'd3, rand_trits(0), rand_trits(0), rand_trits(0), 4'(t + 10));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mute = 1'b0;
      @(negedge clk);
      chk("midreset_count", 128'(count), 128'(0));
      chk("midreset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("midreset_tlu_enable", 128'(bus.tlu_enable), 128'(0));
      bus.rsp_ready = 1'b1;
      repeat (20) tick();
      send(4'd0, rand_trits(0), rand_trits(0), rand_trits(0), 4'd9);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
